// File: rtl/response_encoder.sv
// response_encoder: serializes one response frame (opcode byte followed by a
// big-endian payload) into a byte stream with valid/ready handshakes on both
// the response source side and the byte transmitter side.
// Reset is asynchronous and active-low on the port named 'reset'.
// Optional feature macro: RESPONSE_CHECKSUM_EN appends an XOR checksum byte
// (opcode ^ all payload bytes) after the last payload byte.
module response_encoder #(
  parameter int PAYLOAD_BYTES = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       rsp_valid,
  output logic                       rsp_ready,
  input  logic [7:0]                 rsp_opcode,
  input  logic [8*PAYLOAD_BYTES-1:0] rsp_payload,
  output logic [7:0]                 byte_out,
  output logic                       byte_out_valid,
  input  logic                       byte_out_ready,
  output logic                       busy,
  output logic                       frame_done
);

  localparam int PW = 8 * PAYLOAD_BYTES;
  localparam int CW = $clog2(PAYLOAD_BYTES) + 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(PAYLOAD_BYTES - 1);

`ifdef RESPONSE_CHECKSUM_EN
  typedef enum logic [1:0] {IDLE, SEND_OP, SEND_DATA, SEND_CSUM} state_t;
`else
  typedef enum logic [1:0] {IDLE, SEND_OP, SEND_DATA} state_t;
`endif

  state_t state;
  state_t next_state;

  logic [7:0]    opcode_q;
  logic [PW-1:0] shift_q;
  logic [CW-1:0] count_q;

  logic accept;
  logic xfer;
  logic last_xfer;

  // A frame is taken only in IDLE; a byte moves whenever a byte is being
  // presented and the transmitter is ready.
  assign accept = rsp_valid && (state == IDLE);
  assign xfer   = (state != IDLE) && byte_out_ready;

`ifdef RESPONSE_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] payload_xor;

  // Fold the opcode and every payload byte together at accept time.
  always_comb begin
    payload_xor = rsp_opcode;
    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
      payload_xor = payload_xor ^ rsp_payload[8*i +: 8];
    end
  end

  assign last_xfer = (state == SEND_CSUM) && xfer;
`else
  assign last_xfer = (state == SEND_DATA) && xfer && (count_q == '0);
`endif

  // State register; reset drops any frame in flight immediately.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: advance one phase per transferred byte.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (accept) next_state = SEND_OP;
      end
      SEND_OP: begin
        if (xfer) next_state = SEND_DATA;
      end
      SEND_DATA: begin
        if (xfer && (count_q == '0)) begin
`ifdef RESPONSE_CHECKSUM_EN
          next_state = SEND_CSUM;
`else
          next_state = IDLE;
`endif
        end
      end
`ifdef RESPONSE_CHECKSUM_EN
      SEND_CSUM: begin
        if (xfer) next_state = IDLE;
      end
`endif
      default: next_state = IDLE;
    endcase
  end

  // Datapath: capture the frame at accept, then walk the payload MSB-first.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      opcode_q   <= '0;
      shift_q    <= '0;
      count_q    <= '0;
      frame_done <= 1'b0;
`ifdef RESPONSE_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      frame_done <= last_xfer;
      if (accept) begin
        opcode_q <= rsp_opcode;
        shift_q  <= rsp_payload;
`ifdef RESPONSE_CHECKSUM_EN
        csum_q   <= payload_xor;
`endif
      end else if ((state == SEND_OP) && xfer) begin
        count_q <= LAST_CNT;
      end else if ((state == SEND_DATA) && xfer && (count_q != '0)) begin
        shift_q <= shift_q << 8;
        count_q <= count_q - CW'(1);
      end
    end
  end

  // Output decode: byte_out is forced to zero whenever no byte is offered.
  always_comb begin
    rsp_ready      = 1'b0;
    byte_out       = 8'h00;
    byte_out_valid = 1'b0;
    busy           = 1'b0;
    case (state)
      IDLE: begin
        rsp_ready = 1'b1;
      end
      SEND_OP: begin
        byte_out       = opcode_q;
        byte_out_valid = 1'b1;
        busy           = 1'b1;
      end
      SEND_DATA: begin
        byte_out       = shift_q[PW-1 -: 8];
        byte_out_valid = 1'b1;
        busy           = 1'b1;
      end
`ifdef RESPONSE_CHECKSUM_EN
      SEND_CSUM: begin
        byte_out       = csum_q;
        byte_out_valid = 1'b1;
        busy           = 1'b1;
      end
`endif
      default: begin
        rsp_ready = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_response_encoder.sv
// tb_response_encoder: directed and randomized frames for response_encoder.
// Expected byte streams come from a frame-level model (opcode, payload bytes
// MSB-first, optional XOR checksum) held in a queue.
module tb_response_encoder;

  localparam int PB = 4;
  localparam int PW = 8 * PB;

  logic          clock = 1'b0;
  logic          reset;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [7:0]    rsp_opcode;
  logic [PW-1:0] rsp_payload;
  logic [7:0]    byte_out;
  logic          byte_out_valid;
  logic          byte_out_ready;
  logic          busy;
  logic          frame_done;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  response_encoder #(.PAYLOAD_BYTES(PB)) dut (
    .clock          (clock),
    .reset          (reset),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_opcode     (rsp_opcode),
    .rsp_payload    (rsp_payload),
    .byte_out       (byte_out),
    .byte_out_valid (byte_out_valid),
    .byte_out_ready (byte_out_ready),
    .busy           (busy),
    .frame_done     (frame_done)
  );

  // Free-running clock, 10 time units per period.
  always #5 clock = ~clock;

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Reference model: the byte sequence a frame must produce on the wire.
  task automatic build_frame(input logic [7:0] op, input logic [PW-1:0] pl);
    logic [7:0] b;
    logic [7:0] csum;
    exp_q.delete();
    exp_q.push_back(op);
    csum = op;
    for (int i = 0; i < PB; i++) begin
      b = 8'((pl >> (8 * (PB - 1 - i))) & PW'(8'hFF));
      exp_q.push_back(b);
      csum = csum ^ b;
    end
`ifdef RESPONSE_CHECKSUM_EN
    exp_q.push_back(csum);
`endif
  endtask

  // mode 0: always ready, mode 1: 1,0,0 repeating, mode 2: random
  function automatic logic ready_pattern(input int mode, input int cyc);
    if (mode == 0) return 1'b1;
    if (mode == 1) return (cyc % 3) == 0;
    return 1'(($urandom_range(0, 1)));
  endfunction

  function automatic logic [PW-1:0] rand_payload();
    return PW'({$urandom(), $urandom()});
  endfunction

  // Offer a frame at the current negedge, then follow it byte by byte.
  // Ends at the negedge of the frame_done cycle.
  task automatic send_frame(input logic [7:0] op, input logic [PW-1:0] pl,
                            input int mode, input bit keep_valid,
                            input logic [7:0] nop, input logic [PW-1:0] npl,
                            input bit scramble);
    int idx;
    int cyc;
    logic rdy;
    build_frame(op, pl);
    rsp_valid   = 1'b1;
    rsp_opcode  = op;
    rsp_payload = pl;
    check_output("accept_ready", 64'(rsp_ready), 64'd1);
    @(posedge clock);
    @(negedge clock);
    if (keep_valid) begin
      rsp_opcode  = nop;
      rsp_payload = npl;
    end else begin
      rsp_valid = 1'b0;
    end
    idx = 0;
    cyc = 0;
    while (idx < exp_q.size() && cyc < 100) begin
      check_output("byte_valid", 64'(byte_out_valid), 64'd1);
      check_output("byte_value", 64'(byte_out), 64'(exp_q[idx]));
      check_output("busy_high", 64'(busy), 64'd1);
      check_output("ready_low", 64'(rsp_ready), 64'd0);
      check_output("done_low", 64'(frame_done), 64'd0);
      rdy = ready_pattern(mode, cyc);
      byte_out_ready = rdy;
      if (scramble) begin
        rsp_opcode  = 8'($urandom());
        rsp_payload = rand_payload();
        rsp_valid   = 1'(($urandom_range(0, 1)));
      end
      @(posedge clock);
      @(negedge clock);
      if (rdy) idx++;
      cyc++;
    end
    check_output("frame_len", 64'(idx), 64'(exp_q.size()));
    if (mode == 0) check_output("throughput", 64'(cyc), 64'(exp_q.size()));
    byte_out_ready = 1'(($urandom_range(0, 1)));
    if (!keep_valid) rsp_valid = 1'b0;
    check_output("done_pulse", 64'(frame_done), 64'd1);
    check_output("done_valid", 64'(byte_out_valid), 64'd0);
    check_output("done_byte", 64'(byte_out), 64'd0);
    check_output("done_busy", 64'(busy), 64'd0);
    check_output("done_ready", 64'(rsp_ready), 64'd1);
  endtask

  // Idle cycles with stray byte_out_ready activity that must do nothing.
  task automatic idle_cycles(input int n);
    rsp_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      byte_out_ready = 1'(($urandom_range(0, 1)));
      @(posedge clock);
      @(negedge clock);
      check_output("idle_valid", 64'(byte_out_valid), 64'd0);
      check_output("idle_byte", 64'(byte_out), 64'd0);
      check_output("idle_busy", 64'(busy), 64'd0);
      check_output("idle_done", 64'(frame_done), 64'd0);
      check_output("idle_ready", 64'(rsp_ready), 64'd1);
    end
  endtask

  initial begin
    reset          = 1'b1;
    rsp_valid      = 1'b0;
    rsp_opcode     = 8'h00;
    rsp_payload    = '0;
    byte_out_ready = 1'b0;
    #1 reset = 1'b0;

    // Hold reset for three cycles and look at the reset outputs.
    repeat (3) @(negedge clock);
    check_output("rst_valid", 64'(byte_out_valid), 64'd0);
    check_output("rst_byte", 64'(byte_out), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_done", 64'(frame_done), 64'd0);
    reset = 1'b1;
    #1 check_output("rst_ready", 64'(rsp_ready), 64'd1);
    @(negedge clock);

    $display("[TB] basic frame");
    send_frame(8'hA5, 32'h11223344, 0, 1'b0, 8'h00, '0, 1'b0);
    idle_cycles(1);

    $display("[TB] backpressure");
    send_frame(8'hA5, 32'h11223344, 1, 1'b0, 8'h00, '0, 1'b0);
    idle_cycles(1);

    $display("[TB] back-to-back");
    send_frame(8'h01, 32'hDEADBEEF, 0, 1'b1, 8'h02, 32'hCAFEF00D, 1'b0);
    send_frame(8'h02, 32'hCAFEF00D, 0, 1'b0, 8'h00, '0, 1'b0);
    idle_cycles(1);

    $display("[TB] busy ignore");
    send_frame(8'h3C, 32'h89ABCDEF, 2, 1'b0, 8'h00, '0, 1'b1);
    idle_cycles(1);

    $display("[TB] reset mid-frame");
    build_frame(8'hA5, 32'h11223344);
    rsp_valid   = 1'b1;
    rsp_opcode  = 8'hA5;
    rsp_payload = 32'h11223344;
    @(posedge clock);
    @(negedge clock);
    rsp_valid      = 1'b0;
    byte_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check_output("mid_byte", 64'(byte_out), 64'(exp_q[i]));
      @(posedge clock);
      @(negedge clock);
    end
    check_output("pre_reset_byte", 64'(byte_out), 64'h33);
    #2 reset = 1'b0;
    #1;
    check_output("async_valid", 64'(byte_out_valid), 64'd0);
    check_output("async_byte", 64'(byte_out), 64'd0);
    check_output("async_busy", 64'(busy), 64'd0);
    check_output("async_done", 64'(frame_done), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    check_output("post_reset_done", 64'(frame_done), 64'd0);
    idle_cycles(1);
    send_frame(8'h7E, 32'h00000001, 0, 1'b0, 8'h00, '0, 1'b0);
    idle_cycles(1);

    $display("[TB] random frames");
    for (int f = 0; f < 15; f++) begin
      send_frame(8'($urandom()), rand_payload(), int'($urandom_range(0, 2)),
                 1'b0, 8'h00, '0, 1'(($urandom_range(0, 1))));
      idle_cycles(int'($urandom_range(0, 2)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
